data_memory: RTL and testbench



---
 rtl/data_memory.sv | 73 +++++++
 tb/tb_data_memory.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Data-memory stage: synchronous word RAM plus registered stage result.
// The RAM is built from resettable flops so reset clears every word
// without a clock edge.
module data_memory #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] DM_data,
    input  logic              mem_rw_ex,
    input  logic              mem_en_ex,
    input  logic              mem_mux_sel_dm,
    output logic [DATA_W-1:0] ans_dm
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic [DATA_W-1:0] mem_path;
    logic [DATA_W-1:0] ans_dm_d;
    logic [DATA_W-1:0] ans_dm_q;

    // Upper address bits are dropped, so accesses wrap modulo the depth.
    assign addr  = ans_ex[ADDR_W-1:0];
    assign wr_en = mem_en_ex & mem_rw_ex;

    // Memory-path value: write-through on writes, old contents on reads, zero when idle.
    always_comb begin
        mem_path = '0;
        if (mem_en_ex) begin
            if (mem_rw_ex) begin
                mem_path = DM_data;
            end else begin
                mem_path = mem_q[addr];
            end
        end
    end

    // Stage result select.
    always_comb begin
        ans_dm_d = ans_ex;
        if (mem_mux_sel_dm) begin
            ans_dm_d = mem_path;
        end
    end

    // RAM storage; reset clears all words and blocks writes while held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[addr] <= DM_data;
        end
    end

    // Output register feeding write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ans_dm_q <= '0;
        end else begin
            ans_dm_q <= ans_dm_d;
        end
    end

    assign ans_dm = ans_dm_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus random
// traffic against an array-based reference model.
module tb_data_memory;

    logic        clk;
    logic        reset;
    logic [15:0] ans_ex;
    logic [15:0] DM_data;
    logic        mem_rw_ex;
    logic        mem_en_ex;
    logic        mem_mux_sel_dm;
    logic [15:0] ans_dm;

    int total;
    int bad;

    // Reference model state.
    logic [15:0] ref_mem [256];
    logic [15:0] exp_ans;

    data_memory #(
        .ADDR_W(8),
        .DATA_W(16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ans_ex         (ans_ex),
        .DM_data        (DM_data),
        .mem_rw_ex      (mem_rw_ex),
        .mem_en_ex      (mem_en_ex),
        .mem_mux_sel_dm (mem_mux_sel_dm),
        .ans_dm         (ans_dm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        exp_ans = 16'h0000;
    endtask

    // Drive one access at the falling edge, clock it, update the model, settle.
    task automatic step(input logic [15:0] a, input logic [15:0] d, input logic rw,
                        input logic en, input logic sel);
        logic [15:0] path;
        @(negedge clk);
        ans_ex         = a;
        DM_data        = d;
        mem_rw_ex      = rw;
        mem_en_ex      = en;
        mem_mux_sel_dm = sel;
        @(posedge clk);
        if (!en) begin
            path = 16'h0000;
        end else if (rw) begin
            path = d;
            ref_mem[a[7:0]] = d;
        end else begin
            path = ref_mem[a[7:0]];
        end
        exp_ans = sel ? path : a;
        #1;
    endtask

    task automatic test_reset();
        step(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
        total++;
        if (ans_dm !== 16'h1234) begin
            bad++;
            $display("FAIL pre_reset_value: got %h want %h", ans_dm, 16'h1234);
        end
        // Mid-cycle reset with clk high: must clear without any edge.
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        total++;
        if (ans_dm !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset_clear: got %h want %h", ans_dm, 16'h0000);
        end
        // Attempt a write while reset is held; it must be ignored.
        @(negedge clk);
        ans_ex = 16'h0009; DM_data = 16'hDEAD; mem_rw_ex = 1'b1; mem_en_ex = 1'b1;
        mem_mux_sel_dm = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ans_dm !== 16'h0000) begin
            bad++;
            $display("FAIL reset_hold: got %h want %h", ans_dm, 16'h0000);
        end
        @(negedge clk);
        mem_en_ex = 1'b0;
        reset = 1'b1;
        step(16'h0009, 16'h0000, 1'b0, 1'b1, 1'b1);
        total++;
        if (ans_dm !== 16'h0000) begin
            bad++;
            $display("FAIL write_during_reset: got %h want %h", ans_dm, 16'h0000);
        end
    endtask

    task automatic test_read_after_reset();
        step(16'h0003, 16'h0000, 1'b0, 1'b1, 1'b1);
        total++;
        if (ans_dm !== 16'h0000) begin
            bad++;
            $display("FAIL read_after_reset: got %h want %h", ans_dm, 16'h0000);
        end
    endtask

    task automatic test_write_read();
        step(16'h0003, 16'hFFFF, 1'b1, 1'b1, 1'b1);
        total++;
        if (ans_dm !== 16'hFFFF) begin
            bad++;
            $display("FAIL write_through: got %h want %h", ans_dm, 16'hFFFF);
        end
        step(16'h0003, 16'h0000, 1'b0, 1'b1, 1'b1);
        total++;
        if (ans_dm !== 16'hFFFF) begin
            bad++;
            $display("FAIL read_back: got %h want %h", ans_dm, 16'hFFFF);
        end
        // Write with sel=0: value passes through but the write still commits.
        step(16'h0004, 16'h7777, 1'b1, 1'b1, 1'b0);
        total++;
        if (ans_dm !== 16'h0004) begin
            bad++;
            $display("FAIL write_sel0_output: got %h want %h", ans_dm, 16'h0004);
        end
        step(16'h0004, 16'h0000, 1'b0, 1'b1, 1'b1);
        total++;
        if (ans_dm !== 16'h7777) begin
            bad++;
            $display("FAIL write_sel0_commit: got %h want %h", ans_dm, 16'h7777);
        end
    endtask

    task automatic test_pass_through();
        step(16'h1234, 16'h9999, 1'b0, 1'b0, 1'b0);
        total++;
        if (ans_dm !== 16'h1234) begin
            bad++;
            $display("FAIL pass_through: got %h want %h", ans_dm, 16'h1234);
        end
        step(16'h0003, 16'h0000, 1'b0, 1'b1, 1'b1);
        total++;
        if (ans_dm !== 16'hFFFF) begin
            bad++;
            $display("FAIL pass_ram_unchanged: got %h want %h", ans_dm, 16'hFFFF);
        end
        // Disabled access with sel=1 yields zero.
        step(16'h0003, 16'h0000, 1'b0, 1'b0, 1'b1);
        total++;
        if (ans_dm !== 16'h0000) begin
            bad++;
            $display("FAIL disabled_mem_path: got %h want %h", ans_dm, 16'h0000);
        end
    endtask

    task automatic test_disabled_write_wrap();
        step(16'h0005, 16'hAAAA, 1'b1, 1'b0, 1'b1);
        step(16'h0005, 16'h0000, 1'b0, 1'b1, 1'b1);
        total++;
        if (ans_dm !== 16'h0000) begin
            bad++;
            $display("FAIL disabled_write: got %h want %h", ans_dm, 16'h0000);
        end
        step(16'h0105, 16'h5A5A, 1'b1, 1'b1, 1'b1);
        step(16'h0005, 16'h0000, 1'b0, 1'b1, 1'b1);
        total++;
        if (ans_dm !== 16'h5A5A) begin
            bad++;
            $display("FAIL addr_wrap: got %h want %h", ans_dm, 16'h5A5A);
        end
    endtask

    task automatic test_reset_clears_ram();
        step(16'h0007, 16'hBEEF, 1'b1, 1'b1, 1'b1);
        step(16'h0007, 16'h0000, 1'b0, 1'b1, 1'b1);
        total++;
        if (ans_dm !== 16'hBEEF) begin
            bad++;
            $display("FAIL pre_reset_store: got %h want %h", ans_dm, 16'hBEEF);
        end
        @(negedge clk);
        mem_en_ex = 1'b0;
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        step(16'h0007, 16'h0000, 1'b0, 1'b1, 1'b1);
        total++;
        if (ans_dm !== 16'h0000) begin
            bad++;
            $display("FAIL reset_clears_ram: got %h want %h", ans_dm, 16'h0000);
        end
    endtask

    // Random traffic over a small address window with random upper bits.
    task automatic test_random();
        logic [15:0] a;
        logic [15:0] d;
        for (int n = 0; n < 400; n++) begin
            a = {8'($urandom), 8'($urandom_range(0, 15))};
            d = 16'($urandom);
            step(a, d, 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom));
            total++;
            if (ans_dm !== exp_ans) begin
                bad++;
                $display("FAIL random[%0d]: got %h want %h", n, ans_dm, exp_ans);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        ans_ex = '0;
        DM_data = '0;
        mem_rw_ex = 1'b0;
        mem_en_ex = 1'b0;
        mem_mux_sel_dm = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        total++;
        if (ans_dm !== 16'h0000) begin
            bad++;
            $display("FAIL initial_reset: got %h want %h", ans_dm, 16'h0000);
        end
        reset = 1'b1;

        test_reset();
        test_read_after_reset();
        test_write_read();
        test_pass_through();
        test_disabled_write_wrap();
        test_reset_clears_ram();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
